// File: rtl/mul_share_arbiter_if.sv
// Bus between the requesters, the shared multiplier core and the arbiter; no flow control beyond req/gnt.
// The arbiter takes the slave modport; the requester/core environment takes the master modport.
interface mul_share_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] opa;
  logic [N_REQ*WIDTH-1:0] opb;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]     rsp_product;
  logic                   rsp_err;
  logic                   mul_start;
  logic [WIDTH-1:0]       mul_a;
  logic [WIDTH-1:0]       mul_b;
  logic                   mul_done;
  logic [2*WIDTH-1:0]     mul_product;
  logic                   busy;

  modport slave (
    input  req, opa, opb, mul_done, mul_product,
    output gnt, rsp_valid, rsp_product, rsp_err, mul_start, mul_a, mul_b, busy
  );

  modport master (
    output req, opa, opb, mul_done, mul_product,
    input  gnt, rsp_valid, rsp_product, rsp_err, mul_start, mul_a, mul_b, busy
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one multiplier core; request-to-response is 3 cycles plus core latency.
// One transaction at a time: losers simply hold req until granted; a silent core is aborted after TIMEOUT wait cycles.
module mul_share_arbiter #(
  parameter int WIDTH   = 16,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  mul_share_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [2*WIDTH-1:0] rsp_product_q, rsp_product_d;
  logic               mul_start_q, mul_start_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic               busy_q, busy_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  int                 cand;
  logic [IDX_W-1:0]   cand_idx;

  // First requester at or after ptr, wrapping past N_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = cand[IDX_W-1:0];
      if (!win_found && bus.req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    gnt_d         = gnt_q;
    rsp_valid_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_product_d = rsp_product_q;
    mul_start_d   = 1'b0;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          owner_d     = win_idx;
          gnt_d       = N_REQ'(1) << win_idx;
          mul_a_d     = bus.opa[win_idx*WIDTH +: WIDTH];
          mul_b_d     = bus.opb[win_idx*WIDTH +: WIDTH];
          mul_start_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A completion in the last allowed cycle still beats the abort.
        if (bus.mul_done) begin
          rsp_product_d = bus.mul_product;
          rsp_valid_d   = gnt_q;
          state_d       = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_product_d = '0;
          rsp_valid_d   = gnt_q;
          rsp_err_d     = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        gnt_d   = '0;
        ptr_d   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      owner_q       <= '0;
      cnt_q         <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_product_q <= '0;
      mul_start_q   <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_product_q <= rsp_product_d;
      mul_start_q   <= mul_start_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_product = rsp_product_q;
  assign bus.mul_start   = mul_start_q;
  assign bus.mul_a       = mul_a_q;
  assign bus.mul_b       = mul_b_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed and randomized transactions against a round-robin/transaction-level model of the shared multiplier arbiter.
module tb_mul_share_arbiter;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int TO = 64;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;
  int   mptr;
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];

  mul_share_arbiter_if #(.WIDTH(W), .N_REQ(N)) bus ();

  mul_share_arbiter #(.WIDTH(W), .N_REQ(N), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pack_ops();
    for (int i = 0; i < N; i++) begin
      bus.opa[i*W +: W] = op_a[i];
      bus.opb[i*W +: W] = op_b[i];
    end
  endtask

  // Round-robin rule: first set bit at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] m, input int p);
    for (int j = 0; j < N; j++)
      if (m[(p + j) % N]) return (p + j) % N;
    return -1;
  endfunction

  // lat = 0 means the core never answers; otherwise done is seen in WAIT cycle lat-1.
  task automatic run_txn(input logic [N-1:0] mask, input int lat, input bit drop, input bit spur);
    int            win;
    int            n;
    logic [W-1:0]  ea, eb;
    logic [2*W-1:0] eprod;
    bus.req = mask;
    pack_ops();
    win   = pick(mask, mptr);
    ea    = op_a[win];
    eb    = op_b[win];
    eprod = (lat > 0) ? (2*W)'(ea) * (2*W)'(eb) : '0;
    tick();
    check("grant", bus.gnt, 64'(1) << win);
    check("start_pulse", bus.mul_start, 1);
    check("issue_a", bus.mul_a, ea);
    check("issue_b", bus.mul_b, eb);
    check("busy_issue", bus.busy, 1);
    check("rsp_early", bus.rsp_valid, 0);
    if (spur) begin
      bus.mul_done    = 1'b1;
      bus.mul_product = 32'hDEAD_BEEF;
    end
    if (drop) begin
      op_a[win] = ~ea;
      pack_ops();
      bus.req[win] = 1'b0;
    end
    tick();
    bus.mul_done = 1'b0;
    check("start_single", bus.mul_start, 0);
    n = 0;
    while (bus.rsp_valid == '0 && n < TO + 10) begin
      if (n + 1 == lat) begin
        bus.mul_done    = 1'b1;
        bus.mul_product = eprod;
      end
      tick();
      bus.mul_done    = 1'b0;
      bus.mul_product = $urandom;
      n++;
      check("start_quiet", bus.mul_start, 0);
    end
    check("wait_cycles", n, (lat > 0) ? lat : TO);
    check("rsp_valid", bus.rsp_valid, 64'(1) << win);
    check("rsp_err", bus.rsp_err, (lat > 0) ? 0 : 1);
    check("rsp_product", bus.rsp_product, eprod);
    check("gnt_held", bus.gnt, 64'(1) << win);
    check("a_stable", bus.mul_a, ea);
    mptr = (win + 1) % N;
    tick();
    check("rsp_pulse_end", bus.rsp_valid, 0);
    check("err_pulse_end", bus.rsp_err, 0);
    check("gnt_clear", bus.gnt, 0);
    check("busy_idle", bus.busy, 0);
    check("product_hold", bus.rsp_product, eprod);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    mptr     = 0;
    reset    = 1'b1;
    bus.req         = '0;
    bus.opa         = '0;
    bus.opb         = '0;
    bus.mul_done    = 1'b0;
    bus.mul_product = '0;
    for (int i = 0; i < N; i++) begin
      op_a[i] = W'(i + 1);
      op_b[i] = W'(i + 7);
    end
    tick();
    tick();
    check("rst_gnt", bus.gnt, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_err", bus.rsp_err, 0);
    check("rst_rsp_product", bus.rsp_product, 0);
    check("rst_mul_start", bus.mul_start, 0);
    check("rst_mul_a", bus.mul_a, 0);
    check("rst_mul_b", bus.mul_b, 0);
    check("rst_busy", bus.busy, 0);
    reset = 1'b0;
    tick();
    check("idle_no_req", bus.busy, 0);

    // All four requesting continuously: grant order 0,1,2,3,0.
    for (int t = 0; t < 5; t++) run_txn(4'b1111, 1 + t, 1'b0, 1'b0);

    op_a[0] = 16'd3;
    op_b[0] = 16'd5;
    run_txn(4'b0001, 17, 1'b0, 1'b0);

    run_txn(4'b0100, 0, 1'b0, 1'b0);

    op_a[3] = 16'h1234;
    op_b[3] = 16'h0042;
    run_txn(4'b1000, 4, 1'b1, 1'b0);

    op_a[1] = 16'hFFFF;
    op_b[1] = 16'hFFFF;
    run_txn(4'b0010, 3, 1'b0, 1'b1);
    check("full_width", bus.rsp_product, 32'hFFFE0001);

    // Completion in the very last allowed wait cycle.
    run_txn(4'b0010, TO, 1'b0, 1'b0);

    // Completion pulses while idle are ignored.
    bus.req         = '0;
    bus.mul_done    = 1'b1;
    bus.mul_product = 32'h0BAD_0BAD;
    tick();
    bus.mul_done = 1'b0;
    check("idle_done_rsp", bus.rsp_valid, 0);
    check("idle_done_busy", bus.busy, 0);
    tick();
    check("idle_done_rsp2", bus.rsp_valid, 0);

    // Reset in the middle of WAIT abandons the transaction.
    bus.req = 4'b0010;
    tick();
    check("pre_rst_gnt", bus.gnt, 4'b0010);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("async_rst_gnt", bus.gnt, 0);
    check("async_rst_busy", bus.busy, 0);
    tick();
    reset           = 1'b0;
    bus.req         = '0;
    bus.mul_done    = 1'b1;
    bus.mul_product = 32'h5555_AAAA;
    tick();
    bus.mul_done = 1'b0;
    check("post_rst_rsp", bus.rsp_valid, 0);
    check("post_rst_gnt", bus.gnt, 0);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_prod", bus.rsp_product, 0);
    tick();
    check("post_rst_rsp2", bus.rsp_valid, 0);
    mptr = 0;
    run_txn(4'b1111, 2, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] m;
      int           lat;
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        op_a[i] = W'($urandom);
        op_b[i] = W'($urandom);
      end
      lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      run_txn(m, lat, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
